// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32I fetch stage.
// Owns the PC, fetches over valid/ready and holds the word for decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [24:0] imm_field,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic [1:0]  pcsrc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misaligned
);

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD,
        HALT
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        mis_q;
    logic [31:0] next_pc;
    logic [31:0] jalr_sum;
    logic        take_rsp;
    logic        retire;
    logic        trap;

    // Next-PC select; JALR clears bit 0 before any alignment test.
    always_comb begin
        jalr_sum = rs1_data + imm;
        case (pcsrc)
            2'd1:    next_pc = pc_q + imm;
            2'd2:    next_pc = {jalr_sum[31:1], 1'b0};
            default: next_pc = pc_q + 32'd4;
        endcase
    end

    // Fetch sequencing: request, wait for data, hold until retired.
    always_comb begin
        state_nx = state;
        take_rsp = 1'b0;
        retire   = 1'b0;
        trap     = 1'b0;
        case (state)
            BOOT: state_nx = REQ;
            REQ: begin
                if (imem_req_ready) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    take_rsp = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    if (next_pc[1:0] != 2'b00) begin
                        trap     = 1'b1;
                        state_nx = HALT;
                    end else begin
                        retire   = 1'b1;
                        state_nx = REQ;
                    end
                end
            end
            HALT:    state_nx = HALT;
            default: state_nx = BOOT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nx;
        end
    end

    // PC only advances on a successful retire; a trap leaves it in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (retire) begin
            pc_q <= next_pc;
        end
    end

    // Held word is the NOP whenever no valid instruction is present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_WORD;
        end else if (take_rsp) begin
            instr_q <= imem_rsp_data;
        end else if (state == HOLD && instr_ready) begin
            instr_q <= NOP_WORD;
        end
    end

    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else if (trap) begin
            mis_q <= 1'b1;
        end
    end

    assign imem_req_valid = (state == REQ);
    assign imem_addr      = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = (state == HOLD);
    assign imm_field      = instr_q[31:7];
    assign pc             = pc_q;
    assign pc_plus4       = pc_q + 32'd4;
    assign misaligned     = mis_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for the fetch stage.
// Random handshakes and jumps against a program-trace reference model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RPC  = 32'h0000_0100;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [24:0] imm_field;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [1:0]  pcsrc;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;

    instr_fetch_unit #(
        .RESET_PC(RPC),
        .NOP_WORD(NOP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .instr(instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .imm_field(imm_field),
        .imm(imm),
        .rs1_data(rs1_data),
        .pcsrc(pcsrc),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .misaligned(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    typedef struct {
        logic [1:0]  src;
        logic [31:0] imm;
        logic [31:0] rs1;
    } ctl_t;

    // Stimulus-side knobs, owned by the main process.
    ctl_t        prog[$];
    int          prog_base;
    logic [31:0] dir_list[$];
    bit          dir_active;
    bit          rand_mode;
    bit          hold_req;
    bit          hold_rsp;
    bit          force_dead;
    bit          fast_start;
    bit          timeout_flag;

    // Scoreboard and model state, owned by the monitor.
    int          checks;
    int          failures;
    int          done_cnt;
    int          k;
    int          dir_idx;
    bit          to_seen;
    logic [31:0] pending[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_pc;
    logic [31:0] cur_instr;
    logic [31:0] stall_addr;
    logic [31:0] nx;
    bit          exp_halt;
    bit          exp_mis;
    bit          mis_next;
    bit          in_hold;
    bit          stalled;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act,
                        input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic failx(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got event want none", name);
    endtask

    // Monitor: reset checks, request/response tracking, hold checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk1("rst_req_valid", imem_req_valid, 1'b0);
            chk("rst_addr", imem_addr, RPC);
            chk("rst_instr", instr, NOP);
            chk1("rst_instr_valid", instr_valid, 1'b0);
            chk("rst_imm_field", {7'd0, imm_field}, {7'd0, NOP[31:7]});
            chk("rst_pc", pc, RPC);
            chk("rst_pc_plus4", pc_plus4, RPC + 32'd4);
            chk1("rst_misaligned", misaligned, 1'b0);
            exp_addr_q.delete();
            exp_instr_q.delete();
            pending.delete();
            exp_addr_q.push_back(RPC);
            exp_instr_q.push_back(mem_word(RPC));
            exp_pc   = RPC;
            exp_halt = 1'b0;
            exp_mis  = 1'b0;
            mis_next = 1'b0;
            in_hold  = 1'b0;
            stalled  = 1'b0;
            k        = 0;
            dir_idx  = 0;
        end else begin
            k++;
            if (mis_next) begin
                exp_mis  = 1'b1;
                exp_halt = 1'b1;
                mis_next = 1'b0;
            end
            if (timeout_flag && !to_seen) begin
                to_seen = 1'b1;
                failx("timeout");
            end
            if (k == 1) chk1("boot_no_req", imem_req_valid, 1'b0);
            if (k == 2) begin
                chk1("first_req", imem_req_valid, 1'b1);
                chk("first_addr", imem_addr, RPC);
            end
            if (fast_start && k == 3) chk1("lat_wait", instr_valid, 1'b0);
            if (fast_start && k == 4) chk1("lat_hold", instr_valid, 1'b1);
            chk1("misaligned", misaligned, exp_mis);
            if (exp_halt) begin
                chk1("halt_req", imem_req_valid, 1'b0);
                chk1("halt_valid", instr_valid, 1'b0);
                chk("halt_pc", pc, exp_pc);
            end
            if (stalled) begin
                chk1("stall_valid", imem_req_valid, 1'b1);
                chk("stall_addr", imem_addr, stall_addr);
            end
            stalled = 1'b0;
            if (imem_rsp_valid && pending.size() > 0) begin
                void'(pending.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                if (exp_addr_q.size() == 0) begin
                    failx("unexpected_req");
                end else begin
                    chk("req_addr", imem_addr, exp_addr_q.pop_front());
                end
                if (dir_active && dir_idx < dir_list.size()) begin
                    chk("dir_addr", imem_addr, dir_list[dir_idx]);
                    dir_idx++;
                end
                pending.push_back(imem_addr);
            end else if (imem_req_valid) begin
                stalled    = 1'b1;
                stall_addr = imem_addr;
            end
            if (instr_valid) begin
                if (!in_hold) begin
                    in_hold = 1'b1;
                    if (exp_instr_q.size() == 0) begin
                        failx("unexpected_hold");
                        cur_instr = instr;
                    end else begin
                        cur_instr = exp_instr_q.pop_front();
                    end
                    chk("hold_pc", pc, exp_pc);
                    chk("hold_pc_plus4", pc_plus4, exp_pc + 32'd4);
                    chk("imm_field", {7'd0, imm_field},
                        {7'd0, cur_instr[31:7]});
                end
                chk("instr", instr, cur_instr);
                if (instr_ready) begin
                    in_hold = 1'b0;
                    done_cnt++;
                    case (pcsrc)
                        2'd1:    nx = exp_pc + imm;
                        2'd2:    nx = (rs1_data + imm) & 32'hFFFF_FFFE;
                        default: nx = exp_pc + 32'd4;
                    endcase
                    if (nx % 4 != 0) begin
                        mis_next = 1'b1;
                    end else begin
                        exp_pc = nx;
                        exp_addr_q.push_back(nx);
                        exp_instr_q.push_back(mem_word(nx));
                    end
                end
            end else begin
                if (in_hold) failx("hold_dropped");
                in_hold = 1'b0;
                chk("idle_instr", instr, NOP);
            end
        end
    end

    // Drive all DUT inputs for the coming cycle.
    task automatic drive();
        logic [31:0] r;
        logic [31:0] r2;
        int          idx;
        r  = $urandom;
        r2 = $urandom;
        if (rand_mode) begin
            imem_req_ready = r[23];
            instr_ready    = r[26];
            pcsrc          = r[25:24];
            imm            = {{22{r[9]}}, r[9:2], 2'b00};
            rs1_data       = {20'h0, r[21:12], 1'b0, r[22]};
            if (r[31:27] == 5'd0) begin
                pcsrc = 2'd1;
                imm   = 32'hFFFF_FFFC - exp_pc;
            end
            if (pending.size() > 0 && !hold_rsp) begin
                imem_rsp_valid = r2[0];
                imem_rsp_data  = r2[0] ? mem_word(pending[0]) : r2;
            end else begin
                imem_rsp_valid = (r2[3:1] == 3'd0);
                imem_rsp_data  = DEAD;
            end
        end else begin
            imem_req_ready = !hold_req;
            instr_ready    = 1'b1;
            idx            = done_cnt - prog_base;
            if (idx >= 0 && idx < prog.size()) begin
                pcsrc    = prog[idx].src;
                imm      = prog[idx].imm;
                rs1_data = prog[idx].rs1;
            end else begin
                pcsrc    = 2'd0;
                imm      = 32'd0;
                rs1_data = 32'd0;
            end
            if (pending.size() > 0 && !hold_rsp) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pending[0]);
            end else begin
                imem_rsp_valid = force_dead;
                imem_rsp_data  = DEAD;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic add(input logic [1:0] s, input logic [31:0] i,
                       input logic [31:0] r);
        ctl_t c;
        c.src = s;
        c.imm = i;
        c.rs1 = r;
        prog.push_back(c);
    endtask

    task automatic run_until(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            step();
            n++;
        end
        if (done_cnt < target) timeout_flag = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        instr_ready    = 1'b0;
        imm            = 32'd0;
        rs1_data       = 32'd0;
        pcsrc          = 2'd0;
        rand_mode      = 1'b0;
        hold_req       = 1'b0;
        hold_rsp       = 1'b0;
        force_dead     = 1'b0;
        timeout_flag   = 1'b0;
        fast_start     = 1'b1;
        prog_base      = 0;
        dir_active     = 1'b1;
        dir_list       = '{32'h100, 32'h104, 32'h108, 32'h10C,
                           32'h200, 32'h1F0, 32'h304};
        add(2'd0, 32'd0, 32'd0);
        add(2'd0, 32'd0, 32'd0);
        add(2'd0, 32'd0, 32'd0);
        add(2'd1, 32'h0000_00F4, 32'd0);
        add(2'd1, 32'hFFFF_FFF0, 32'd0);
        add(2'd2, 32'h0000_0004, 32'h0000_0301);
        add(2'd0, 32'd0, 32'd0);

        // Straight-line fetch, branch and JALR at full speed.
        repeat (3) step();
        prog_base = done_cnt;
        rst_n     = 1'b1;
        run_until(prog_base + 7, 100);

        // Reset while a response is outstanding, then a late response.
        fast_start = 1'b0;
        dir_active = 1'b0;
        hold_rsp   = 1'b1;
        begin
            int n;
            n = 0;
            while (pending.size() == 0 && n < 50) begin
                step();
                n++;
            end
            if (pending.size() == 0) timeout_flag = 1'b1;
        end
        step();
        rst_n      = 1'b0;
        force_dead = 1'b1;
        hold_req   = 1'b1;
        drive();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        force_dead = 1'b0;
        repeat (2) step();
        hold_req = 1'b0;
        hold_rsp = 1'b0;
        run_until(done_cnt + 2, 100);

        // Random handshakes, jumps and wrap-around.
        rand_mode = 1'b1;
        run_until(done_cnt + 150, 4000);

        // Misaligned branch target traps and halts.
        rand_mode = 1'b0;
        step();
        rst_n = 1'b0;
        drive();
        repeat (2) step();
        prog.delete();
        add(2'd1, 32'hFFFF_FF40, 32'd0);
        add(2'd1, 32'h0000_0006, 32'd0);
        dir_list   = '{32'h100, 32'h40};
        dir_active = 1'b1;
        prog_base  = done_cnt;
        rst_n      = 1'b1;
        run_until(prog_base + 2, 100);
        repeat (10) step();

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
